// File: rtl/counter_prog.sv
// rtl/counter_prog.sv - programmable up/down counter with prescaler, terminal-count pulse and sticky flags
module counter_prog #(
  parameter int WIDTH     = 8,
  parameter int PRE_WIDTH = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 VPWR,
  input  logic                 VGND,
  input  logic                 en,
  input  logic                 dn,
  input  logic                 load,
  input  logic [WIDTH-1:0]     data,
  input  logic [WIDTH-1:0]     limit,
  input  logic                 sat,
  input  logic [PRE_WIDTH-1:0] pre,
  input  logic                 clr_flags,
  output logic [WIDTH-1:0]     count,
  output logic                 tc,
  output logic                 ovf,
  output logic                 unf
);

  // Power pins exist only for the hardened flow; they carry no logic function.
  logic unused_pwr;
  assign unused_pwr = VPWR ^ VGND;

  logic [WIDTH-1:0]     count_q, count_d;
  logic [PRE_WIDTH-1:0] pre_cnt_q, pre_cnt_d;
  logic                 tc_q, tc_d;
  logic                 ovf_q, ovf_d;
  logic                 unf_q, unf_d;
  logic                 step;
  logic                 set_ovf, set_unf;

  // A step is due when the prescaler has seen pre+1 enabled cycles.
  assign step = en && (pre_cnt_q == pre);

  // Next-state: load beats step, step beats hold; set events beat clr_flags.
  always_comb begin
    count_d   = count_q;
    pre_cnt_d = pre_cnt_q;
    tc_d      = 1'b0;
    set_ovf   = 1'b0;
    set_unf   = 1'b0;

    if (load) begin
      count_d   = (data > limit) ? limit : data;
      pre_cnt_d = '0;
    end else begin
      if (en) begin
        pre_cnt_d = step ? '0 : pre_cnt_q + 1'b1;
      end
      if (step) begin
        if (!dn) begin
          // At or above limit counts as the top boundary, so a lowered limit
          // is caught on the next up step.
          if (count_q >= limit) begin
            count_d = sat ? limit : '0;
            tc_d    = 1'b1;
            set_ovf = 1'b1;
          end else begin
            count_d = count_q + 1'b1;
          end
        end else begin
          if (count_q == '0) begin
            count_d = sat ? '0 : limit;
            tc_d    = 1'b1;
            set_unf = 1'b1;
          end else if (count_q > limit) begin
            // Limit was lowered below the count: snap back into range quietly.
            count_d = limit;
          end else begin
            count_d = count_q - 1'b1;
          end
        end
      end
    end

    ovf_d = set_ovf | (ovf_q & ~clr_flags);
    unf_d = set_unf | (unf_q & ~clr_flags);
  end

  // State registers; reset discards prescaler progress along with the count.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q   <= '0;
      pre_cnt_q <= '0;
      tc_q      <= 1'b0;
      ovf_q     <= 1'b0;
      unf_q     <= 1'b0;
    end else begin
      count_q   <= count_d;
      pre_cnt_q <= pre_cnt_d;
      tc_q      <= tc_d;
      ovf_q     <= ovf_d;
      unf_q     <= unf_d;
    end
  end

  assign count = count_q;
  assign tc    = tc_q;
  assign ovf   = ovf_q;
  assign unf   = unf_q;

endmodule

// File: tb/tb_counter_prog.sv
// tb/tb_counter_prog.sv - randomized and directed bench for counter_prog against a reference model
module tb_counter_prog;

  localparam int W  = 4;
  localparam int PW = 3;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          VPWR = 1'b1;
  logic          VGND = 1'b0;
  logic          en = 1'b0;
  logic          dn = 1'b0;
  logic          load = 1'b0;
  logic [W-1:0]  data = '0;
  logic [W-1:0]  limit = '0;
  logic          sat = 1'b0;
  logic [PW-1:0] pre = '0;
  logic          clr_flags = 1'b0;
  logic [W-1:0]  count;
  logic          tc, ovf, unf;

  int total = 0;
  int bad   = 0;

  // Reference model state, plain integers.
  int m_count = 0;
  int m_pre   = 0;
  int m_tc    = 0;
  int m_ovf   = 0;
  int m_unf   = 0;

  always #5 clk = ~clk;

  counter_prog #(.WIDTH(W), .PRE_WIDTH(PW)) dut (
    .clk(clk), .rst_n(rst_n), .VPWR(VPWR), .VGND(VGND),
    .en(en), .dn(dn), .load(load), .data(data), .limit(limit),
    .sat(sat), .pre(pre), .clr_flags(clr_flags),
    .count(count), .tc(tc), .ovf(ovf), .unf(unf)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    m_count = 0; m_pre = 0; m_tc = 0; m_ovf = 0; m_unf = 0;
  endtask

  // One rising edge of the behavioural counter, from the currently driven inputs.
  task automatic model_edge();
    int lim, so, su;
    bit stp;
    if (!rst_n) begin
      model_reset();
      return;
    end
    lim = int'(limit);
    so = 0; su = 0; m_tc = 0;
    if (load) begin
      m_count = (int'(data) > lim) ? lim : int'(data);
      m_pre = 0;
    end else begin
      stp = en && (m_pre == int'(pre));
      if (en) m_pre = stp ? 0 : (m_pre + 1) % (1 << PW);
      if (stp && !dn) begin
        if (m_count >= lim) begin
          m_count = sat ? lim : 0; m_tc = 1; so = 1;
        end else m_count = m_count + 1;
      end else if (stp && dn) begin
        if (m_count == 0) begin
          m_count = sat ? 0 : lim; m_tc = 1; su = 1;
        end else if (m_count > lim) m_count = lim;
        else m_count = m_count - 1;
      end
    end
    m_ovf = (so != 0 || (m_ovf != 0 && !clr_flags)) ? 1 : 0;
    m_unf = (su != 0 || (m_unf != 0 && !clr_flags)) ? 1 : 0;
  endtask

  task automatic check_all(input string tag);
    check({tag, ".count"}, 32'(count), 32'(m_count));
    check({tag, ".tc"},    32'(tc),    32'(m_tc));
    check({tag, ".ovf"},   32'(ovf),   32'(m_ovf));
    check({tag, ".unf"},   32'(unf),   32'(m_unf));
  endtask

  task automatic tick(input string tag);
    model_edge();
    @(posedge clk);
    #1;
    check_all(tag);
  endtask

  initial begin
    // Reset state
    tick("reset");
    tick("reset");
    check("reset_count", 32'(count), 0);
    rst_n = 1'b1;

    // Up wrap: limit 9, pre 0
    limit = 4'd9; sat = 1'b0; pre = '0; en = 1'b1; dn = 1'b0;
    for (int i = 1; i <= 9; i++) begin
      tick("upwrap");
      check("upwrap_val", 32'(count), 32'(i));
    end
    tick("upwrap_edge10");
    check("upwrap_zero", 32'(count), 0);
    check("upwrap_tc", 32'(tc), 1);
    tick("upwrap_after");
    check("upwrap_tc_drop", 32'(tc), 0);
    check("upwrap_ovf", 32'(ovf), 1);

    // Async reset with count at 6, between edges
    en = 1'b0; load = 1'b1; data = 4'd6;
    tick("load6");
    load = 1'b0;
    check("load6_val", 32'(count), 6);
    rst_n = 1'b0;
    #2;
    model_reset();
    check_all("async_rst");
    tick("rst_hold");
    tick("rst_hold");
    rst_n = 1'b1; en = 1'b1; pre = '0;
    tick("rst_release");
    check("rst_resume", 32'(count), 1);

    // Down saturate from 2
    en = 1'b0; clr_flags = 1'b1;
    tick("clr");
    clr_flags = 1'b0;
    load = 1'b1; data = 4'd2; sat = 1'b1; dn = 1'b1; en = 1'b1;
    tick("dsat_load");
    load = 1'b0;
    for (int i = 1; i <= 4; i++) begin
      tick("dsat");
      if (i == 2) check("dsat_tc_lo", 32'(tc), 0);
      if (i == 3) check("dsat_tc_hi", 32'(tc), 1);
      if (i == 4) check("dsat_tc_again", 32'(tc), 1);
    end
    check("dsat_count", 32'(count), 0);
    check("dsat_unf", 32'(unf), 1);
    check("dsat_ovf", 32'(ovf), 0);

    // Prescaler pre=2 from reset
    rst_n = 1'b0;
    tick("pre_rst");
    rst_n = 1'b1; pre = 3'd2; en = 1'b1; dn = 1'b0; sat = 1'b0; limit = 4'd9;
    for (int e = 1; e <= 7; e++) begin
      tick("pre");
      if (e == 2) check("pre_e2", 32'(count), 0);
      if (e == 3) check("pre_e3", 32'(count), 1);
      if (e == 6) check("pre_e6", 32'(count), 2);
    end
    en = 1'b0;
    for (int i = 0; i < 5; i++) tick("pre_hold");
    check("pre_hold_val", 32'(count), 2);
    en = 1'b1;
    tick("pre_ret1");
    check("pre_ret1_val", 32'(count), 2);
    tick("pre_ret2");
    check("pre_ret2_val", 32'(count), 3);

    // Load clamp beats a due step, then lowered limit on down step
    clr_flags = 1'b1; en = 1'b0;
    tick("clr2");
    clr_flags = 1'b0;
    limit = 4'd9; pre = '0; en = 1'b1; dn = 1'b0; data = 4'd12; load = 1'b1;
    tick("clamp");
    check("clamp_val", 32'(count), 9);
    check("clamp_tc", 32'(tc), 0);
    load = 1'b0; dn = 1'b1; limit = 4'd5;
    tick("lower");
    check("lower_val", 32'(count), 5);
    check("lower_unf", 32'(unf), 0);

    // Flag clear race
    dn = 1'b0; limit = 4'd3; sat = 1'b0; load = 1'b1; data = 4'd3;
    tick("race_load");
    load = 1'b0; clr_flags = 1'b1;
    tick("race_wrap");
    check("race_ovf_set", 32'(ovf), 1);
    en = 1'b0;
    tick("race_clr");
    check("race_ovf_clr", 32'(ovf), 0);
    clr_flags = 1'b0;

    // limit=0: every step is a boundary
    limit = '0; en = 1'b1; pre = '0; dn = 1'b0;
    tick("lim0_up");
    check("lim0_tc", 32'(tc), 1);
    dn = 1'b1;
    tick("lim0_dn");
    check("lim0_unf", 32'(unf), 1);

    // Randomized traffic
    for (int i = 0; i < 3000; i++) begin
      en        = ($urandom_range(0, 3) != 0);
      dn        = 1'($urandom);
      sat       = 1'($urandom);
      load      = ($urandom_range(0, 15) == 0);
      data      = W'($urandom);
      limit     = ($urandom_range(0, 7) == 0) ? '0 : W'($urandom);
      pre       = ($urandom_range(0, 1) == 0) ? '0 : PW'($urandom);
      clr_flags = ($urandom_range(0, 9) == 0);
      rst_n     = ($urandom_range(0, 199) != 0);
      tick("rand");
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
